// File: rtl/rr_arbiter_wlock_if.sv
// rtl/rr_arbiter_wlock_if.sv - request/grant bundle between requesters and one arbiter
//
// Purpose: groups the request side (REQ, LAST, EN, WEIGHT) and the grant side
// (GRT, GRT_VLD, GRT_IDX, LOCKED) of one output-port arbiter.
// Modports:
//   master - requester/allocator side: drives REQ, LAST, EN, WEIGHT; sees grant
//   slave  - arbiter side: sees requests, drives GRT, GRT_VLD, GRT_IDX, LOCKED
// Parameters: NR requesters, WW weight bits per requester, PW index width.
interface rr_arbiter_wlock_if #(
  parameter int NR = 5,
  parameter int WW = 3,
  parameter int PW = (NR > 1) ? $clog2(NR) : 1
);
  logic [NR-1:0]    REQ;
  logic [NR-1:0]    LAST;
  logic             EN;
  logic [NR*WW-1:0] WEIGHT;
  logic [NR-1:0]    GRT;
  logic             GRT_VLD;
  logic [PW-1:0]    GRT_IDX;
  logic             LOCKED;

  modport master (
    output REQ, LAST, EN, WEIGHT,
    input  GRT, GRT_VLD, GRT_IDX, LOCKED
  );

  modport slave (
    input  REQ, LAST, EN, WEIGHT,
    output GRT, GRT_VLD, GRT_IDX, LOCKED
  );
endinterface

// File: rtl/rr_arbiter_wlock.sv
// rtl/rr_arbiter_wlock.sv - weighted round-robin arbiter with packet lock
//
// Purpose: switch-allocation arbiter for one router output port. A head flit
// that is not a tail locks the grant to its requester until the tail flit
// transfers. On each tail, the priority pointer moves past the winner once it
// has sent its weight's worth of packets.
// Optional feature: macro ARB_WEIGHT_EN enables per-requester weights; when it
// is undefined, WEIGHT is ignored and every requester gets one packet per turn.
// Ports:
//   CLK  - clock
//   RST  - synchronous reset, active-high
//   bus  - rr_arbiter_wlock_if.slave:
//          REQ/LAST/EN/WEIGHT in, GRT/GRT_VLD/GRT_IDX/LOCKED out
// The grant is combinational from registered state and the current REQ.
module rr_arbiter_wlock #(
  parameter int NR = 5,
  parameter int WW = 3
) (
  input  logic              CLK,
  input  logic              RST,
  rr_arbiter_wlock_if.slave bus
);
  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] owner, owner_nxt;

  logic [NR-1:0] grt;
  logic [PW-1:0] win;
  logic          found;
  logic          vld;
  logic          xfer;
  logic [PW-1:0] ptr_adv;

`ifdef ARB_WEIGHT_EN
  logic [WW-1:0] cnt, cnt_nxt;
  logic [WW-1:0] cnt_eff;
  logic [WW-1:0] wsel;
  logic [WW:0]   weff;
  logic [WW:0]   cnt_inc;
`else
  logic          unused_weight;
  assign unused_weight = ^bus.WEIGHT;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      ptr   <= '0;
      owner <= '0;
`ifdef ARB_WEIGHT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
`ifdef ARB_WEIGHT_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    grt       = '0;
    win       = '0;
    found     = 1'b0;
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    ptr_adv   = '0;
`ifdef ARB_WEIGHT_EN
    cnt_nxt   = cnt;
    cnt_eff   = '0;
    wsel      = '0;
    weff      = '0;
    cnt_inc   = '0;
`endif

    if (!RST) begin
      if (state == S_LOCKED) begin
        // Only the owner may continue; others wait even if the owner stalls.
        if (bus.REQ[owner]) begin
          grt[owner] = 1'b1;
          win        = owner;
        end
      end else begin
        // First pass: requesters at or above the pointer; second pass wraps.
        for (int i = 0; i < NR; i++) begin
          if (!found && bus.REQ[i] && (PW'(i) >= ptr)) begin
            found = 1'b1;
            win   = PW'(i);
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (!found && bus.REQ[i]) begin
            found = 1'b1;
            win   = PW'(i);
          end
        end
        if (found) grt[win] = 1'b1;
      end
    end

    vld  = |grt;
    xfer = vld & bus.EN;

    ptr_adv = (win == PW'(NR - 1)) ? '0 : win + 1'b1;

`ifdef ARB_WEIGHT_EN
    for (int i = 0; i < NR; i++) begin
      if (win == PW'(i)) wsel = bus.WEIGHT[i*WW +: WW];
    end
    weff = (wsel == '0) ? (WW+1)'(1) : {1'b0, wsel};
    // The running count belongs to whoever the pointer is parked on; a
    // different winner starts its own count from zero.
    cnt_eff = (win == ptr) ? cnt : '0;
    cnt_inc = {1'b0, cnt_eff} + (WW+1)'(1);
`endif

    if (xfer) begin
      if (!bus.LAST[win]) begin
        state_nxt = S_LOCKED;
        owner_nxt = win;
`ifdef ARB_WEIGHT_EN
        cnt_nxt   = cnt_eff;
`endif
      end else begin
        state_nxt = S_IDLE;
`ifdef ARB_WEIGHT_EN
        if (cnt_inc >= weff) begin
          ptr_nxt = ptr_adv;
          cnt_nxt = '0;
        end else begin
          // Winner keeps top priority for its next packet.
          ptr_nxt = win;
          cnt_nxt = cnt_inc[WW-1:0];
        end
`else
        ptr_nxt = ptr_adv;
`endif
      end
    end
  end

  assign bus.GRT     = grt;
  assign bus.GRT_VLD = vld;
  assign bus.GRT_IDX = vld ? win : '0;
  assign bus.LOCKED  = !RST && (state == S_LOCKED);

endmodule
